// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared constants for the MEM-stage access unit
// Purpose: size encodings, FSM state codes, default ack timeout, alignment helper.
// Ports: none (package).
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_NONE = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_WORD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int TIMEOUT_DEFAULT = 255;

  // Half needs bit 0 clear, word needs both low bits clear; bytes never fault.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr);
    return ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - load lane extraction and extension
// Purpose: pick the addressed byte/half/word out of a read word, little-endian.
// Ports: i_rdata (read word), i_addr (byte offset), i_size (SZ_*),
//        i_unsigned (1 = zero-extend), o_data (extended result).
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[{i_addr, 3'b000} +: 8];
    w_half = i_rdata[{i_addr[1], 4'b0000} +: 16];
    o_data = i_rdata;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SZ_HALF: o_data = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage data-memory access unit
// Purpose: req/ack data-memory transaction, store lane steering, load
//          extraction, pipeline stall and write-back value generation.
// Ports: clk/reset (sync, active-high); EX/MEM fields MemRead, MemWrite,
//        mem_unsigned, MemtoReg, RegWrite, Aluout, busB, rd; memory bus
//        dm_req/dm_we/dm_addr/dm_be/dm_wdata out, dm_rdata/dm_ack in;
//        mem_stall, wb_data/wb_regwrite/wb_rd, misalign and bus_err pulses.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  MemRead,
  input  logic [1:0]  MemWrite,
  input  logic        mem_unsigned,
  input  logic        MemtoReg,
  input  logic        RegWrite,
  input  logic [31:0] Aluout,
  input  logic [31:0] busB,
  input  logic [4:0]  rd,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        mem_stall,
  output logic [31:0] wb_data,
  output logic        wb_regwrite,
  output logic [4:0]  wb_rd,
  output logic        misalign,
  output logic        bus_err
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_load;
  logic        r_err;

  logic        w_store;
  logic        w_access;
  logic [1:0]  w_size;
  logic        w_misal;
  logic        w_go;
  logic        w_busy;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_val;

  // A store wins when both sizes are nonzero.
  assign w_store  = (MemWrite != SZ_NONE);
  assign w_access = w_store || (MemRead != SZ_NONE);
  assign w_size   = w_store ? MemWrite : MemRead;
  assign w_misal  = (r_state == ST_IDLE) && w_access && is_misaligned(w_size, Aluout[1:0]);
  assign w_go     = (r_state == ST_IDLE) && w_access && !w_misal;
  assign w_busy   = (r_state == ST_BUSY);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = busB;
    case (w_size)
      SZ_BYTE: begin
        w_be    = 4'b0001 << Aluout[1:0];
        w_wdata = {4{busB[7:0]}};
      end
      SZ_HALF: begin
        w_be    = Aluout[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{busB[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = busB;
      end
    endcase
  end

  load_align u_load_align (
    .i_rdata    (dm_rdata),
    .i_addr     (Aluout[1:0]),
    .i_size     (w_size),
    .i_unsigned (mem_unsigned),
    .o_data     (w_load_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
      r_load  <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_go) begin
            r_cnt <= 8'd0;
            r_err <= 1'b0;
            if (dm_ack) begin
              r_load  <= w_load_val;
              r_state <= ST_DONE;
            end else begin
              r_state <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          if (dm_ack) begin
            r_load  <= w_load_val;
            r_state <= ST_DONE;
          end else if (r_cnt == LP_LAST) begin
            r_load  <= 32'd0;
            r_err   <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Request qualifiers come only from state and EX/MEM fields, never dm_ack.
  assign dm_req    = w_go || w_busy;
  assign mem_stall = dm_req;
  assign dm_we     = dm_req && w_store;
  assign dm_be     = dm_req ? w_be : 4'b0000;
  assign dm_addr   = {Aluout[31:2], 2'b00};
  assign dm_wdata  = w_wdata;
  assign misalign  = w_misal;

  // The timeout pulse is reported in the DONE cycle that the error lands in.
  assign bus_err     = (r_state == ST_DONE) && r_err;
  assign wb_data     = MemtoReg ? r_load : Aluout;
  assign wb_regwrite = RegWrite && !misalign && !bus_err && !mem_stall;
  assign wb_rd       = rd;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  MemRead, MemWrite;
  logic        mem_unsigned, MemtoReg, RegWrite;
  logic [31:0] Aluout, busB;
  logic [4:0]  rd;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic [3:0]  dm_be;
  logic        dm_ack;
  logic        mem_stall;
  logic [31:0] wb_data;
  logic        wb_regwrite;
  logic [4:0]  wb_rd;
  logic        misalign, bus_err;

  typedef struct {
    logic [31:0] data;
    logic        we;
  } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int stalls;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_unsigned(mem_unsigned),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Aluout(Aluout), .busB(busB), .rd(rd),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_stall(mem_stall), .wb_data(wb_data), .wb_regwrite(wb_regwrite),
    .wb_rd(wb_rd), .misalign(misalign), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble;
    MemRead = 2'b00; MemWrite = 2'b00; mem_unsigned = 1'b0;
    MemtoReg = 1'b0; RegWrite = 1'b0; Aluout = 32'd0; busB = 32'd0; rd = 5'd0;
  endtask

  task automatic instr(input logic [1:0] mr, input logic [1:0] mw, input logic uns,
                       input logic m2r, input logic rw, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] d);
    MemRead = mr; MemWrite = mw; mem_unsigned = uns; MemtoReg = m2r;
    RegWrite = rw; Aluout = a; busB = b; rd = d;
    #1;
  endtask

  // Memory model: acks after ack_at stall cycles, counts stall cycles.
  task automatic mem_cycle(input int ack_at, input logic [31:0] rdat, output int n);
    n = 0;
    while (mem_stall === 1'b1 && n < 40) begin
      dm_ack   = (n == ack_at);
      dm_rdata = dm_ack ? rdat : 32'hDEAD_BEEF;
      tick();
      n++;
    end
    dm_ack = 1'b0;
    dm_rdata = 32'd0;
    if (n >= 40) check("stall_bound", 32'(n), 32'd0);
  endtask

  // DONE cycle: compare write-back against the oldest expectation.
  task automatic retire;
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("wb_data", wb_data, e.data);
      check("wb_regwrite", {31'd0, wb_regwrite}, {31'd0, e.we});
      check("done_stall", {31'd0, mem_stall}, 32'd0);
      check("done_req", {31'd0, dm_req}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; dm_ack = 1'b0; dm_rdata = 32'd0;
    bubble();
    tick(); tick();
    check("rst_req", {31'd0, dm_req}, 32'd0);
    check("rst_we", {31'd0, dm_we}, 32'd0);
    check("rst_be", {28'd0, dm_be}, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    check("rst_bus_err", {31'd0, bus_err}, 32'd0);
    check("rst_wb_regwrite", {31'd0, wb_regwrite}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    reset = 1'b0;
    tick();

    // Non-memory ALU op passes straight through.
    instr(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h55, 32'd0, 5'd7);
    check("alu_wb_data", wb_data, 32'h55);
    check("alu_wb_regwrite", {31'd0, wb_regwrite}, 32'd1);
    check("alu_stall", {31'd0, mem_stall}, 32'd0);
    check("alu_wb_rd", {27'd0, wb_rd}, 32'd7);
    tick();

    // Store byte at 0x1003, ack on the third stall cycle.
    instr(2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 32'h1003, 32'hAABBCCDD, 5'd0);
    exp_q.push_back('{32'h1003, 1'b0});
    check("sb_req", {31'd0, dm_req}, 32'd1);
    check("sb_we", {31'd0, dm_we}, 32'd1);
    check("sb_be", {28'd0, dm_be}, 32'h8);
    check("sb_wdata", dm_wdata, 32'hDDDDDDDD);
    check("sb_addr", dm_addr, 32'h1000);
    mem_cycle(2, 32'd0, stalls);
    check("sb_stalls", 32'(stalls), 32'd3);
    retire();
    bubble(); tick();

    // Signed byte load, lane 1.
    instr(2'b01, 2'b00, 1'b0, 1'b1, 1'b1, 32'h2001, 32'd0, 5'd3);
    exp_q.push_back('{32'hFFFFFFF0, 1'b1});
    check("lb_we", {31'd0, dm_we}, 32'd0);
    mem_cycle(1, 32'h0000F000, stalls);
    check("lb_stalls", 32'(stalls), 32'd2);
    retire();
    bubble(); tick();

    // Unsigned byte load, same lane.
    instr(2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 32'h2001, 32'd0, 5'd3);
    exp_q.push_back('{32'h000000F0, 1'b1});
    mem_cycle(1, 32'h0000F000, stalls);
    retire();
    bubble(); tick();

    // Unsigned half load, upper half.
    instr(2'b10, 2'b00, 1'b1, 1'b1, 1'b1, 32'h2002, 32'd0, 5'd4);
    exp_q.push_back('{32'h00008001, 1'b1});
    mem_cycle(1, 32'h80011234, stalls);
    retire();
    bubble(); tick();

    // Word load with same-cycle ack: one stall cycle.
    instr(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 32'h2004, 32'd0, 5'd5);
    exp_q.push_back('{32'h12345678, 1'b1});
    check("lw_be", {28'd0, dm_be}, 32'hF);
    check("lw_addr", dm_addr, 32'h2004);
    mem_cycle(0, 32'h12345678, stalls);
    check("lw_stalls", 32'(stalls), 32'd1);
    retire();
    bubble(); tick();

    // Misaligned word store: no request, one-cycle misalign, no write-back.
    instr(2'b00, 2'b11, 1'b0, 1'b0, 1'b1, 32'h3002, 32'h11111111, 5'd6);
    check("mis_req", {31'd0, dm_req}, 32'd0);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    check("mis_regwrite", {31'd0, wb_regwrite}, 32'd0);
    check("mis_stall", {31'd0, mem_stall}, 32'd0);
    tick();
    bubble(); #1;
    check("mis_clear", {31'd0, misalign}, 32'd0);
    tick();

    // Half store at 0x3002 with MemRead also set: store wins.
    instr(2'b11, 2'b10, 1'b0, 1'b0, 1'b0, 32'h3002, 32'h0000BEEF, 5'd0);
    exp_q.push_back('{32'h3002, 1'b0});
    check("sh_we", {31'd0, dm_we}, 32'd1);
    check("sh_be", {28'd0, dm_be}, 32'hC);
    check("sh_wdata", dm_wdata, 32'hBEEFBEEF);
    check("sh_misalign", {31'd0, misalign}, 32'd0);
    mem_cycle(0, 32'd0, stalls);
    retire();
    bubble(); tick();

    // Timeout with TIMEOUT=4: IDLE + 4 BUSY cycles, then DONE with error.
    instr(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 32'h4000, 32'd0, 5'd9);
    exp_q.push_back('{32'h0, 1'b0});
    mem_cycle(99, 32'd0, stalls);
    check("to_stalls", 32'(stalls), 32'd5);
    check("to_bus_err", {31'd0, bus_err}, 32'd1);
    retire();
    bubble(); tick();
    check("to_bus_err_clear", {31'd0, bus_err}, 32'd0);

    // Reset during BUSY abandons the request; a late ack is ignored.
    instr(2'b11, 2'b00, 1'b0, 1'b1, 1'b1, 32'h5000, 32'd0, 5'd1);
    tick(); tick();
    check("rb_busy_req", {31'd0, dm_req}, 32'd1);
    reset = 1'b1;
    bubble(); #1;
    tick();
    check("rb_req_after", {31'd0, dm_req}, 32'd0);
    reset = 1'b0;
    MemtoReg = 1'b1;
    dm_ack = 1'b1; dm_rdata = 32'hFFFFFFFF;
    tick();
    dm_ack = 1'b0; dm_rdata = 32'd0;
    #1;
    check("rb_late_ack_req", {31'd0, dm_req}, 32'd0);
    check("rb_late_ack_load", wb_data, 32'd0);
    check("rb_stall", {31'd0, mem_stall}, 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
